prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Control-side counterpart of the program counter: generates `init`, `halt`, `Branch_abs` and `Target`, and consumes the PC value fed back from it.
- Runs one of three programs per `Start` request: resets the PC, jumps to the program base if it is non-zero, and resolves branches through a loadable target LUT.
- Detects end-of-program and signals completion to the testbench through a `Start`/`Done` handshake.

Parameters:
- PC_W, 10, PC width.
- TGT_W, 16, Target width; LUT entries are zero-extended from PC_W.
- LUT_AW, 5, LUT address width (32 entries).
- END_PC, 63, PC value treated as end of program.
- MAX_CYCLES, 16'hFFFF, RUN-cycle timeout.
- BASE1, 0; BASE2, 128; BASE3, 256. Start addresses for programs 1, 2 and 3.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  request a program run.
- ProgSel  in  2  program select: 1, 2 or 3 (0 is treated as 1).
- PC  in  PC_W  current program counter.
- InstrHalt  in  1  decoded halt instruction at PC.
- BrUncond  in  1  unconditional branch at PC.
- BrZero  in  1  branch-if-zero at PC.
- ALU_zero  in  1  ALU zero flag.
- LutIdx  in  LUT_AW  branch target index.
- LutWe  in  1  LUT write enable.
- LutWAddr  in  LUT_AW  LUT write address.
- LutWData  in  PC_W  LUT write data.
- init  out  1  PC reset.
- halt  out  1  PC freeze.
- Branch_abs  out  1  PC absolute jump.
- Target  out  TGT_W  jump target.
- Done  out  1  program finished.
- Timeout  out  1  finished by cycle limit.
- CycleCount  out  16  RUN cycles of the last or current run.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all 32 LUT entries=0; CycleCount=0; Timeout=0; sel register=1.
  - Outputs: init=0, halt=1, Branch_abs=0, Target=0, Done=0.
- States: IDLE, INIT, LAUNCH, RUN, DONE.
- IDLE:
  - halt=1.
  - Start=1 -> INIT; latch ProgSel (0 maps to 1).
- INIT (exactly 1 cycle):
  - init=1, halt=0; CycleCount<=0; Timeout<=0.
  - Next state: LAUNCH if the selected base is non-zero, else RUN.
- LAUNCH (exactly 1 cycle):
  - Branch_abs=1, Target=selected base, halt=0.
  - Next state: RUN.
- RUN:
  - halt_evt = InstrHalt | (PC==END_PC) | (CycleCount==MAX_CYCLES-1).
  - halt=halt_evt (combinational), so the PC freezes at the halting address.
  - Branch_abs = !halt_evt & (BrUncond | (BrZero & ALU_zero)).
  - Target = zero-extended LUT[LutIdx], combinational read.
  - CycleCount increments every RUN cycle, saturating at 16'hFFFF.
  - halt_evt -> DONE. Timeout<=1 if the cycle limit caused the event, even when another halt cause coincides.
  - Start is ignored in RUN.
- DONE:
  - Done=1, halt=1; CycleCount and Timeout hold.
  - Start=1 -> INIT with newly latched ProgSel. Done drops in the INIT cycle.
- init, Branch_abs and Target are 0 in every state except where stated above.
- LUT write:
  - Synchronous on posedge when LutWe=1, legal in any state.
  - A same-cycle read of the same address returns the old value.
- Latency:
  - Start to init: 1 cycle.
  - Start to the first RUN cycle: 2 cycles (base 0) or 3 cycles (base non-zero).
  - halt_evt to Done: 1 cycle.
- Reset asserted mid-RUN: returns to IDLE immediately, halt=1, and the LUT is cleared.
- PC wrap-around is the PC's responsibility. The sequencer only compares PC against END_PC; it never checks range or wraps.

Test Plan:
- Reset, LUT[3]<=40, Start with ProgSel=1, BrUncond=1 with LutIdx=3 on the 2nd RUN cycle -> init for 1 cycle, then Branch_abs=1 with Target=40, then the PC runs to 63 -> halt=1, Done=1, PC held at 63.
- Start with ProgSel=2 -> INIT then LAUNCH with Branch_abs=1 and Target=128; the first RUN cycle sees PC=128.
- BrZero=1: with ALU_zero=0 -> Branch_abs=0; with ALU_zero=1 -> Branch_abs=1. InstrHalt=1 and BrUncond=1 in the same cycle -> Branch_abs=0, halt=1, then DONE.
- MAX_CYCLES=8, program never halts -> DONE after 8 RUN cycles, CycleCount=8, Timeout=1.
- Start pulsed during RUN -> no effect. Start in DONE with ProgSel=0 -> program 1 restarts, CycleCount cleared.
- Reset asserted mid-RUN, asynchronously between edges -> halt=1 and Done=0 immediately, LUT reads 0, state IDLE.

Source files
------------

// File: rtl/prog_sequencer.sv
// Control-side sequencer for the program counter: start/init/launch/run/done
// handshake, branch resolution through a loadable target LUT, end/timeout detect.
module prog_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned TGT_W      = 16,
    parameter int unsigned LUT_AW     = 5,
    parameter int unsigned END_PC     = 63,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
    parameter int unsigned BASE1      = 0,
    parameter int unsigned BASE2      = 128,
    parameter int unsigned BASE3      = 256
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        ProgSel,
    input  logic [PC_W-1:0]   PC,
    input  logic              InstrHalt,
    input  logic              BrUncond,
    input  logic              BrZero,
    input  logic              ALU_zero,
    input  logic [LUT_AW-1:0] LutIdx,
    input  logic              LutWe,
    input  logic [LUT_AW-1:0] LutWAddr,
    input  logic [PC_W-1:0]   LutWData,
    output logic              init,
    output logic              halt,
    output logic              Branch_abs,
    output logic [TGT_W-1:0]  Target,
    output logic              Done,
    output logic              Timeout,
    output logic [15:0]       CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic [PC_W-1:0] lut_q [2**LUT_AW];
    logic [PC_W-1:0] base;
    logic            cyc_lim;
    logic            halt_evt;
    logic            br_take;

    always_comb begin
        unique case (sel_q)
            2'd2:    base = PC_W'(BASE2);
            2'd3:    base = PC_W'(BASE3);
            default: base = PC_W'(BASE1);
        endcase
    end

    assign cyc_lim  = (cnt_q == (MAX_CYCLES - 16'd1));
    assign halt_evt = InstrHalt | (PC == PC_W'(END_PC)) | cyc_lim;
    assign br_take  = BrUncond | (BrZero & ALU_zero);

    assign Timeout    = tmo_q;
    assign CycleCount = cnt_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd1;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Write lands at the edge, so a same-cycle read still sees the old entry
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) begin
                lut_q[i] <= '0;
            end
        end else if (LutWe) begin
            lut_q[LutWAddr] <= LutWData;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        init       = 1'b0;
        halt       = 1'b1;
        Branch_abs = 1'b0;
        Target     = '0;
        Done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_INIT;
                    sel_d   = (ProgSel == 2'd0) ? 2'd1 : ProgSel;
                end
            end
            S_INIT: begin
                init    = 1'b1;
                halt    = 1'b0;
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = (base != '0) ? S_LAUNCH : S_RUN;
            end
            S_LAUNCH: begin
                halt       = 1'b0;
                Branch_abs = 1'b1;
                Target     = TGT_W'(base);
                state_d    = S_RUN;
            end
            S_RUN: begin
                halt       = halt_evt;
                Branch_abs = !halt_evt && br_take;
                Target     = TGT_W'(lut_q[LutIdx]);
                cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (halt_evt) begin
                    state_d = S_DONE;
                    tmo_d   = cyc_lim;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                if (Start) begin
                    state_d = S_INIT;
                    sel_d   = (ProgSel == 2'd0) ? 2'd1 : ProgSel;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus random traffic, all
// checked each cycle against a run-level behavioural model and a PC model.
module tb_prog_sequencer;

    localparam int unsigned PC_W   = 10;
    localparam int unsigned TGT_W  = 16;
    localparam int unsigned LUT_AW = 5;
    localparam int unsigned MAXC   = 32;

    logic              CLK, Reset, Start;
    logic [1:0]        ProgSel;
    logic [PC_W-1:0]   PC;
    logic              InstrHalt, BrUncond, BrZero, ALU_zero;
    logic [LUT_AW-1:0] LutIdx, LutWAddr;
    logic              LutWe;
    logic [PC_W-1:0]   LutWData;
    logic              init, halt, Branch_abs, Done, Timeout;
    logic [TGT_W-1:0]  Target;
    logic [15:0]       CycleCount;

    int checks = 0;
    int failures = 0;

    prog_sequencer #(
        .PC_W(PC_W), .TGT_W(TGT_W), .LUT_AW(LUT_AW), .END_PC(63),
        .MAX_CYCLES(16'(MAXC)), .BASE1(0), .BASE2(128), .BASE3(256)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .PC(PC), .InstrHalt(InstrHalt), .BrUncond(BrUncond),
        .BrZero(BrZero), .ALU_zero(ALU_zero), .LutIdx(LutIdx),
        .LutWe(LutWe), .LutWAddr(LutWAddr), .LutWData(LutWData),
        .init(init), .halt(halt), .Branch_abs(Branch_abs),
        .Target(Target), .Done(Done), .Timeout(Timeout),
        .CycleCount(CycleCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Program counter environment driven by the sequencer outputs
    always @(posedge CLK or posedge Reset) begin
        if (Reset) PC <= '0;
        else if (init) PC <= '0;
        else if (halt) PC <= PC;
        else if (Branch_abs) PC <= Target[PC_W-1:0];
        else PC <= PC + 1'b1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: a run is a count of cycles since Start was accepted
    bit          m_busy, m_fin, m_to;
    int          m_k, m_cc, m_base;
    logic [9:0]  m_lut [32];

    function automatic int base_of(input logic [1:0] s);
        if (s == 2'd2) return 128;
        if (s == 2'd3) return 256;
        return 0;
    endfunction

    always @(negedge CLK) begin
        bit e_init, e_halt, e_br, evt, take;
        int e_tgt;
        e_init = 0; e_halt = 1; e_br = 0; e_tgt = 0;
        evt = 0;
        take = BrUncond || (BrZero && ALU_zero);
        if (Reset) begin
            m_busy = 0; m_fin = 0; m_to = 0; m_k = 0; m_cc = 0; m_base = 0;
            foreach (m_lut[i]) m_lut[i] = '0;
        end else if (m_busy && m_k == 0) begin
            e_init = 1; e_halt = 0;
        end else if (m_busy && m_k == 1) begin
            e_halt = 0; e_br = 1; e_tgt = m_base;
        end else if (m_busy) begin
            evt = InstrHalt || (PC == 10'd63) || (m_cc == MAXC - 1);
            e_halt = evt;
            e_br = !evt && take;
            e_tgt = int'(m_lut[LutIdx]);
        end
        chk("init", init, e_init);
        chk("halt", halt, e_halt);
        chk("branch", Branch_abs, e_br);
        chk("target", Target, e_tgt);
        chk("done", Done, !Reset && !m_busy && m_fin);
        chk("timeout", Timeout, m_to);
        chk("cyclecount", CycleCount, m_cc);
        if (!Reset) begin
            if (!m_busy) begin
                if (Start) begin
                    m_busy = 1; m_fin = 0; m_k = 0;
                    m_base = base_of(ProgSel);
                end
            end else if (m_k == 0) begin
                m_cc = 0; m_to = 0;
                m_k = (m_base != 0) ? 1 : 2;
            end else if (m_k == 1) begin
                m_k = 2;
            end else begin
                if (evt) begin
                    m_to = (m_cc == MAXC - 1);
                    m_busy = 0; m_fin = 1;
                end
                m_cc = (m_cc == 65535) ? m_cc : m_cc + 1;
                m_k++;
            end
            if (LutWe) m_lut[LutWAddr] = LutWData;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!Done && n < lim) begin
            step();
            n++;
        end
        chk("done_wait", Done, 1);
    endtask

    task automatic quiet();
        Start = 0; ProgSel = 0; InstrHalt = 0; BrUncond = 0; BrZero = 0;
        ALU_zero = 0; LutIdx = 0; LutWe = 0; LutWAddr = 0; LutWData = 0;
    endtask

    initial begin
        Reset = 1;
        quiet();
        repeat (3) step();
        @(negedge CLK);
        chk("rst_halt", halt, 1);
        chk("rst_done", Done, 0);
        chk("rst_cc", CycleCount, 0);
        step();
        Reset = 0;
        LutWe = 1; LutWAddr = 3; LutWData = 40;
        step();
        LutWe = 0; Start = 1; ProgSel = 1;
        step();
        Start = 0;
        @(negedge CLK);
        chk("p1_init", init, 1);
        step();
        @(negedge CLK);
        chk("p1_pc0", PC, 0);
        step();
        BrUncond = 1; LutIdx = 3;
        @(negedge CLK);
        chk("p1_br", Branch_abs, 1);
        chk("p1_tgt", Target, 40);
        step();
        BrUncond = 0;
        @(negedge CLK);
        chk("p1_pc40", PC, 40);
        step();
        wait_done(60);
        chk("p1_pcend", PC, 63);
        chk("p1_cc", CycleCount, 26);
        chk("p1_to", Timeout, 0);

        Start = 1; ProgSel = 2;
        step();
        Start = 0;
        @(negedge CLK);
        chk("p2_init", init, 1);
        chk("p2_done_drop", Done, 0);
        step();
        @(negedge CLK);
        chk("p2_launch", Branch_abs, 1);
        chk("p2_tgt", Target, 128);
        step();
        BrZero = 1; LutIdx = 5; ALU_zero = 0;
        @(negedge CLK);
        chk("p2_pc128", PC, 128);
        chk("bz_nz", Branch_abs, 0);
        step();
        ALU_zero = 1;
        @(negedge CLK);
        chk("bz_z", Branch_abs, 1);
        step();
        BrZero = 0; ALU_zero = 0;
        step();
        Start = 1; ProgSel = 3;
        step();
        Start = 0;
        @(negedge CLK);
        chk("run_start_ign", PC, 2);
        chk("run_no_init", init, 0);
        step();
        wait_done(60);
        chk("tmo_cc", CycleCount, 32);
        chk("tmo_flag", Timeout, 1);
        chk("tmo_pc", PC, 29);

        Start = 1; ProgSel = 0;
        step();
        Start = 0;
        @(negedge CLK);
        chk("p0_cc_hold", CycleCount, 32);
        step();
        @(negedge CLK);
        chk("p0_pc", PC, 0);
        chk("p0_cc_clr", CycleCount, 0);
        chk("p0_to_clr", Timeout, 0);
        step();
        step();
        InstrHalt = 1; BrUncond = 1; LutIdx = 3;
        @(negedge CLK);
        chk("hb_br", Branch_abs, 0);
        chk("hb_halt", halt, 1);
        step();
        quiet();
        @(negedge CLK);
        chk("hb_done", Done, 1);
        chk("hb_cc", CycleCount, 3);
        chk("hb_pc", PC, 2);

        for (int i = 0; i < 3000; i++) begin
            step();
            Start     = ($urandom_range(0, 7) == 0);
            ProgSel   = 2'($urandom);
            InstrHalt = ($urandom_range(0, 15) == 0);
            BrUncond  = ($urandom_range(0, 7) == 0);
            BrZero    = ($urandom_range(0, 3) == 0);
            ALU_zero  = 1'($urandom);
            LutIdx    = 5'($urandom);
            LutWe     = ($urandom_range(0, 3) == 0);
            LutWAddr  = 5'($urandom);
            LutWData  = ($urandom_range(0, 1) == 0) ?
                        10'($urandom_range(40, 70)) : 10'($urandom);
        end

        step();
        quiet();
        Reset = 1;
        step();
        Reset = 0;
        LutWe = 1; LutWAddr = 3; LutWData = 40;
        step();
        LutWe = 0; Start = 1; ProgSel = 1;
        step();
        Start = 0;
        step();
        step();
        #3 Reset = 1;
        #1;
        chk("ar_halt", halt, 1);
        chk("ar_done", Done, 0);
        chk("ar_cc", CycleCount, 0);
        @(negedge CLK);
        step();
        Reset = 0; Start = 1; ProgSel = 1;
        step();
        Start = 0;
        step();
        BrUncond = 1; LutIdx = 3;
        @(negedge CLK);
        chk("ar_lut_clr", Target, 0);
        step();
        BrUncond = 0;
        wait_done(80);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
